adc_decimator: RTL and testbench

ADC_DECIMATOR -- requirements
Module: adc_decimator

---
 rtl/adc_pkg.sv | 8 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/adc_decimator.sv | 89 ++++++++
 tb/tb_adc_decimator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC sample width and sample type
package adc_pkg;

    localparam int ADC_W = 12;

    typedef logic [ADC_W-1:0] adc_sample_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_push;
    logic w_pop;

    assign empty  = (r_level == '0);
    assign full   = (r_level == (AW+1)'(DEPTH));
    assign w_pop  = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign w_push = push && (!full || w_pop);

    assign dout  = empty ? '0 : r_mem[r_rd_ptr];
    assign level = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + (AW+1)'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clear)
            r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/adc_decimator.sv
// rtl/adc_decimator.sv - block-average decimator feeding an output FIFO
// Optional round-half-up averaging enabled by macro ADC_DECIMATOR_ROUND_EN.
module adc_decimator
    import adc_pkg::*;
#(
    parameter int LOG2_N = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADC_W-1:0]         data_i,
    input  logic                     valid_i,
    input  logic                     clear_i,
    output logic [ADC_W-1:0]         data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overrun_o
);

    localparam int ACC_W = ADC_W + LOG2_N;
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2**LOG2_N) - 1);
`ifdef ADC_DECIMATOR_ROUND_EN
    localparam logic [ACC_W-1:0] RND_ADD = ACC_W'((2**LOG2_N) / 2);
`else
    localparam logic [ACC_W-1:0] RND_ADD = '0;
`endif

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_overrun;

    logic [ACC_W-1:0] w_sum;
    adc_sample_t      w_avg;
    logic             w_last;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;

    assign w_sum  = r_acc + ACC_W'(data_i);
    assign w_avg  = ADC_W'((w_sum + RND_ADD) >> LOG2_N);
    assign w_last = valid_i && (r_count == CNT_LAST);
    assign w_pop  = !w_empty && ready_i;
    assign w_drop = w_last && w_full && !w_pop;

    assign valid_o   = !w_empty;
    assign overrun_o = r_overrun;

    sync_fifo #(
        .WIDTH (ADC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_i),
        .push  (w_last && !clear_i),
        .pop   (ready_i && !clear_i),
        .din   (w_avg),
        .dout  (data_o),
        .full  (w_full),
        .empty (w_empty),
        .level (level_o)
    );

    // A dropped average still restarts the block so the next window stays aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (clear_i) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (valid_i) begin
            if (w_last) begin
                r_acc   <= '0;
                r_count <= '0;
                if (w_drop) r_overrun <= 1'b1;
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_adc_decimator.sv
// tb/tb_adc_decimator.sv - directed self-checking bench for adc_decimator (LOG2_N=2, DEPTH=4)
module tb_adc_decimator;

    logic        clk;
    logic        rst_n;
    logic [11:0] data_i;
    logic        valid_i;
    logic        clear_i;
    logic [11:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  level_o;
    logic        overrun_o;

    int errors;
    int checks;

    typedef struct {
        int s0;
        int s1;
        int s2;
        int s3;
        int exp_trunc;
        int exp_round;
    } vec_t;

    vec_t vecs [6];

    adc_decimator #(.LOG2_N(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .clear_i   (clear_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .level_o   (level_o),
        .overrun_o (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic pop);
        data_i  = 12'(s);
        valid_i = 1'b1;
        ready_i = pop;
        step();
        valid_i = 1'b0;
        ready_i = 1'b0;
    endtask

    task automatic pop1();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    task automatic block(input int v);
        for (int k = 0; k < 4; k++) send(v, 1'b0);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    function automatic int pick(input vec_t v);
`ifdef ADC_DECIMATOR_ROUND_EN
        return v.exp_round;
`else
        return v.exp_trunc;
`endif
    endfunction

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        data_i  = '0;
        valid_i = 1'b0;
        clear_i = 1'b0;
        ready_i = 1'b0;

        vecs[0] = '{100, 101, 102, 103, 101, 102};
        vecs[1] = '{4095, 4095, 4095, 4095, 4095, 4095};
        vecs[2] = '{0, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 2, 3, 4, 2, 3};
        vecs[4] = '{7, 7, 7, 8, 7, 7};
        vecs[5] = '{0, 0, 0, 3, 0, 1};

        #12;
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_level", int'(level_o), 0);
        chk("reset_overrun", int'(overrun_o), 0);
        chk("reset_data", int'(data_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk("pop_empty_level", int'(level_o), 0);
        chk("pop_empty_valid", int'(valid_o), 0);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].s0, 1'b0);
            send(vecs[i].s1, 1'b0);
            send(vecs[i].s2, 1'b0);
            chk($sformatf("vec%0d_not_yet", i), int'(valid_o), 0);
            send(vecs[i].s3, 1'b0);
            chk($sformatf("vec%0d_valid", i), int'(valid_o), 1);
            chk($sformatf("vec%0d_data", i), int'(data_o), pick(vecs[i]));
            chk($sformatf("vec%0d_level", i), int'(level_o), 1);
            pop1();
            chk($sformatf("vec%0d_drained", i), int'(level_o), 0);
        end

        for (int b = 1; b <= 5; b++) block(b * 10);
        chk("ovr_level", int'(level_o), 4);
        chk("ovr_flag", int'(overrun_o), 1);
        for (int b = 1; b <= 4; b++) begin
            chk($sformatf("ovr_drain%0d", b), int'(data_o), b * 10);
            pop1();
        end
        chk("ovr_empty", int'(valid_o), 0);
        chk("ovr_sticky", int'(overrun_o), 1);
        do_clear();
        chk("ovr_cleared", int'(overrun_o), 0);

        for (int b = 1; b <= 4; b++) block(b * 10);
        send(50, 1'b0);
        send(50, 1'b0);
        send(50, 1'b0);
        send(50, 1'b1);
        chk("fullpop_level", int'(level_o), 4);
        chk("fullpop_overrun", int'(overrun_o), 0);
        for (int b = 2; b <= 5; b++) begin
            chk($sformatf("fullpop_drain%0d", b), int'(data_o), b * 10);
            pop1();
        end
        chk("fullpop_empty", int'(level_o), 0);

        send(1000, 1'b0);
        send(1000, 1'b0);
        do_clear();
        block(8);
        chk("clr_data", int'(data_o), 8);
        chk("clr_level", int'(level_o), 1);
        chk("clr_overrun", int'(overrun_o), 0);
        pop1();

        block(5);
        block(6);
        block(7);
        send(99, 1'b0);
        send(99, 1'b0);
        chk("rst_pre_level", int'(level_o), 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_level", int'(level_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_overrun", int'(overrun_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        block(20);
        chk("rst_after_data", int'(data_o), 20);
        chk("rst_after_level", int'(level_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
